exec_mem_unit: RTL and testbench

//  Execute/memory datapath slice of the 8-bit pipelined CPU: a combinational 8-bit ALU,
//  a combinational 8-bit barrel shifter (shift/rotate), and a 256x8 data memory.

---
 rtl/exec_mem_unit.sv | 157 +++++++++++++++
 tb/tb_exec_mem_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_mem_unit.sv
// Execute/memory slice of the 8-bit CPU: combinational ALU and barrel shifter,
// 256x8 data memory with asynchronous read, and the registered C/Z status flags.
module exec_mem_unit #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    alu_op,
  input  logic [DW-1:0] alu_a,
  input  logic [DW-1:0] alu_b,
  input  logic          alu_use_c,
  output logic [DW-1:0] alu_out,
  output logic          alu_co,
  output logic          alu_z,
  input  logic [DW-1:0] sh_data,
  input  logic [2:0]    sh_count,
  input  logic          sh_dir,
  input  logic          sh_shift,
  output logic [DW-1:0] sh_out,
  output logic          sh_c,
  output logic          sh_z,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  input  logic          sel_c,
  input  logic          sel_z,
  input  logic          wr_c,
  input  logic          wr_z,
  output logic          c_flag,
  output logic          z_flag,
  output logic          next_c,
  output logic          next_z
);

  localparam int unsigned DEPTH = 1 << AW;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_PASA = 3'b110;

  logic          r_c;
  logic          r_z;
  logic [DW-1:0] r_mem [0:DEPTH-1];

  logic          w_cin;
  logic [DW:0]   w_ext_a;
  logic [DW:0]   w_ext_b;
  logic [DW:0]   w_ext_cin;
  logic [DW:0]   w_arith;
  logic [DW-1:0] w_alu_out;
  logic          w_alu_co;
  logic [DW-1:0] w_sh_out;
  logic          w_sh_c;
  logic [2:0]    w_inv;

  assign w_cin     = alu_use_c & r_c;
  assign w_ext_a   = {1'b0, alu_a};
  assign w_ext_b   = {1'b0, alu_b};
  assign w_ext_cin = {{DW{1'b0}}, w_cin};

  // ALU: the extra top bit of the 9-bit sum/difference is carry or borrow
  always_comb begin
    w_arith   = '0;
    w_alu_out = '0;
    w_alu_co  = 1'b0;
    case (alu_op)
      OP_ADD: begin
        w_arith   = w_ext_a + w_ext_b + w_ext_cin;
        w_alu_out = w_arith[DW-1:0];
        w_alu_co  = w_arith[DW];
      end
      OP_SUB: begin
        w_arith   = w_ext_a - w_ext_b - w_ext_cin;
        w_alu_out = w_arith[DW-1:0];
        w_alu_co  = w_arith[DW];
      end
      OP_AND:  w_alu_out = alu_a & alu_b;
      OP_OR:   w_alu_out = alu_a | alu_b;
      OP_XOR:  w_alu_out = alu_a ^ alu_b;
      OP_NOT:  w_alu_out = ~alu_a;
      OP_PASA: w_alu_out = alu_a;
      default: w_alu_out = alu_b;
    endcase
  end

  assign alu_out = w_alu_out;
  assign alu_co  = w_alu_co;
  assign alu_z   = (w_alu_out == '0);

  // Barrel shifter; w_inv = 8 - n is the complementary rotate amount
  always_comb begin
    w_inv    = 3'(4'd8 - {1'b0, sh_count});
    w_sh_out = sh_data;
    w_sh_c   = 1'b0;
    case ({sh_dir, sh_shift})
      2'b01: begin
        w_sh_out = sh_data << sh_count;
        w_sh_c   = sh_data[w_inv];
      end
      2'b11: begin
        w_sh_out = sh_data >> sh_count;
        w_sh_c   = sh_data[sh_count - 3'd1];
      end
      2'b00: begin
        w_sh_out = (sh_data << sh_count) | (sh_data >> w_inv);
        w_sh_c   = w_sh_out[0];
      end
      default: begin
        w_sh_out = (sh_data >> sh_count) | (sh_data << w_inv);
        w_sh_c   = w_sh_out[DW-1];
      end
    endcase
    if (sh_count == 3'd0) begin
      w_sh_out = sh_data;
      w_sh_c   = 1'b0;
    end
  end

  assign sh_out = w_sh_out;
  assign sh_c   = w_sh_c;
  assign sh_z   = (w_sh_out == '0);

  assign next_c = sel_c ? w_sh_c : w_alu_co;
  assign next_z = sel_z ? sh_z : alu_z;

  // Status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c <= 1'b0;
      r_z <= 1'b0;
    end else begin
      if (wr_c) r_c <= next_c;
      if (wr_z) r_z <= next_z;
    end
  end

  assign c_flag = r_c;
  assign z_flag = r_z;

  // Data memory: whole array clears on reset, reads are combinational
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[AW'(i)] <= '0;
    end else if (mem_we) begin
      r_mem[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = r_mem[mem_addr];

endmodule

// File: tb/tb_exec_mem_unit.sv
// Bench for exec_mem_unit: directed literal cases followed by random traffic,
// all outputs compared every negative edge against a behavioural model.
module tb_exec_mem_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] alu_op = '0;
  logic [7:0] alu_a = '0, alu_b = '0;
  logic       alu_use_c = 1'b0;
  logic [7:0] alu_out;
  logic       alu_co, alu_z;
  logic [7:0] sh_data = '0;
  logic [2:0] sh_count = '0;
  logic       sh_dir = 1'b0, sh_shift = 1'b0;
  logic [7:0] sh_out;
  logic       sh_c, sh_z;
  logic       mem_we = 1'b0;
  logic [7:0] mem_addr = '0, mem_wdata = '0;
  logic [7:0] mem_rdata;
  logic       sel_c = 1'b0, sel_z = 1'b0, wr_c = 1'b0, wr_z = 1'b0;
  logic       c_flag, z_flag, next_c, next_z;

  int n_pass = 0;
  int n_total = 0;

  exec_mem_unit dut (
    .clk(clk), .reset(reset),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_use_c(alu_use_c),
    .alu_out(alu_out), .alu_co(alu_co), .alu_z(alu_z),
    .sh_data(sh_data), .sh_count(sh_count), .sh_dir(sh_dir), .sh_shift(sh_shift),
    .sh_out(sh_out), .sh_c(sh_c), .sh_z(sh_z),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .sel_c(sel_c), .sel_z(sel_z), .wr_c(wr_c), .wr_z(wr_z),
    .c_flag(c_flag), .z_flag(z_flag), .next_c(next_c), .next_z(next_z)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [7:0] m_mem [0:255];
  logic       m_c = 1'b0;
  logic       m_z = 1'b0;

  // {carry, result} from plain integer arithmetic
  function automatic logic [8:0] m_alu(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b, input logic cin);
    int r;
    logic [7:0] o;
    logic co;
    co = 1'b0;
    r  = 0;
    case (op)
      3'd0: begin r = int'(a) + int'(b) + int'(cin); co = (r > 255); o = 8'(r); end
      3'd1: begin r = int'(a) - int'(b) - int'(cin); co = (r < 0);   o = 8'(r); end
      3'd2: o = a & b;
      3'd3: o = a | b;
      3'd4: o = a ^ b;
      3'd5: o = ~a;
      3'd6: o = a;
      default: o = b;
    endcase
    return {co, o};
  endfunction

  // {carry, result}: move one bit per step, carry is the last bit moved out/around
  function automatic logic [8:0] m_sh(input logic [7:0] d, input logic [2:0] n,
                                      input logic dir, input logic shift);
    logic [7:0] v;
    logic c;
    v = d;
    c = 1'b0;
    for (int k = 0; k < int'(n); k++) begin
      if (!dir) begin
        c = v[7];
        v = {v[6:0], shift ? 1'b0 : v[7]};
      end else begin
        c = v[0];
        v = {shift ? 1'b0 : v[0], v[7:1]};
      end
    end
    return {c, v};
  endfunction

  function automatic logic [8:0] exp_alu();
    return m_alu(alu_op, alu_a, alu_b, alu_use_c & m_c);
  endfunction

  function automatic logic [8:0] exp_sh();
    return m_sh(sh_data, sh_count, sh_dir, sh_shift);
  endfunction

  function automatic logic exp_next_c();
    logic [8:0] ra, rs;
    ra = exp_alu();
    rs = exp_sh();
    return sel_c ? rs[8] : ra[8];
  endfunction

  function automatic logic exp_next_z();
    logic [8:0] ra, rs;
    ra = exp_alu();
    rs = exp_sh();
    return sel_z ? (rs[7:0] == 8'h00) : (ra[7:0] == 8'h00);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) m_mem[i] <= 8'h00;
      m_c <= 1'b0;
      m_z <= 1'b0;
    end else begin
      if (wr_c) m_c <= exp_next_c();
      if (wr_z) m_z <= exp_next_z();
      if (mem_we) m_mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Compare every output to the model on each falling edge
  always @(negedge clk) begin
    logic [8:0] ea, es;
    ea = exp_alu();
    es = exp_sh();
    chk("alu_out",   32'(alu_out),   32'(ea[7:0]));
    chk("alu_co",    32'(alu_co),    32'(ea[8]));
    chk("alu_z",     32'(alu_z),     32'(ea[7:0] == 8'h00));
    chk("sh_out",    32'(sh_out),    32'(es[7:0]));
    chk("sh_c",      32'(sh_c),      32'(es[8]));
    chk("sh_z",      32'(sh_z),      32'(es[7:0] == 8'h00));
    chk("mem_rdata", 32'(mem_rdata), 32'(m_mem[mem_addr]));
    chk("c_flag",    32'(c_flag),    32'(m_c));
    chk("z_flag",    32'(z_flag),    32'(m_z));
    chk("next_c",    32'(next_c),    32'(exp_next_c()));
    chk("next_z",    32'(next_z),    32'(exp_next_z()));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_c_flag", 32'(c_flag), 32'd0);
    chk("rst_z_flag", 32'(z_flag), 32'd0);
    chk("rst_rdata",  32'(mem_rdata), 32'd0);
    #10 reset = 1'b0;

    // ADD overflow to zero, then load flags from the ALU
    step();
    alu_op = 3'd0; alu_a = 8'hFF; alu_b = 8'h01; alu_use_c = 1'b0;
    #2;
    chk("add_out", 32'(alu_out), 32'h00);
    chk("add_co",  32'(alu_co),  32'd1);
    chk("add_z",   32'(alu_z),   32'd1);
    wr_c = 1'b1; wr_z = 1'b1; sel_c = 1'b0; sel_z = 1'b0;
    step();
    wr_c = 1'b0; wr_z = 1'b0;
    #2;
    chk("add_c_flag", 32'(c_flag), 32'd1);
    chk("add_z_flag", 32'(z_flag), 32'd1);

    // ADC with C=1, SUB with borrow
    alu_a = 8'h10; alu_b = 8'h20; alu_use_c = 1'b1;
    #2;
    chk("adc_out", 32'(alu_out), 32'h31);
    chk("adc_co",  32'(alu_co),  32'd0);
    alu_op = 3'd1; alu_a = 8'h05; alu_b = 8'h07; alu_use_c = 1'b0;
    #2;
    chk("sub_out", 32'(alu_out), 32'hFE);
    chk("sub_co",  32'(alu_co),  32'd1);

    // Shifter corner cases
    sh_data = 8'h81; sh_count = 3'd1; sh_dir = 1'b0; sh_shift = 1'b1;
    #1;
    chk("shl_out", 32'(sh_out), 32'h02);
    chk("shl_c",   32'(sh_c),   32'd1);
    sh_dir = 1'b1; sh_shift = 1'b0;
    #1;
    chk("rotr_out", 32'(sh_out), 32'hC0);
    chk("rotr_c",   32'(sh_c),   32'd1);
    sh_data = 8'h08; sh_count = 3'd3; sh_shift = 1'b1;
    #1;
    chk("shr_out", 32'(sh_out), 32'h01);
    chk("shr_c",   32'(sh_c),   32'd0);
    sh_data = 8'h5A; sh_count = 3'd0;
    #1;
    chk("sh0_out", 32'(sh_out), 32'h5A);
    chk("sh0_c",   32'(sh_c),   32'd0);

    // Memory writes; old value visible until the edge
    step();
    mem_we = 1'b1; mem_addr = 8'h10; mem_wdata = 8'hA5;
    #2;
    chk("wr_old_10", 32'(mem_rdata), 32'h00);
    step();
    mem_addr = 8'hFF; mem_wdata = 8'h5A;
    #2;
    chk("wr_old_ff", 32'(mem_rdata), 32'h00);
    step();
    mem_we = 1'b0; mem_addr = 8'h10;
    #2;
    chk("rd_10", 32'(mem_rdata), 32'hA5);
    mem_addr = 8'hFF;
    #1;
    chk("rd_ff", 32'(mem_rdata), 32'h5A);

    // Flags from the shifter, then hold
    alu_op = 3'd0; alu_a = 8'h01; alu_b = 8'h01; alu_use_c = 1'b0;
    sh_data = 8'h80; sh_count = 3'd1; sh_dir = 1'b0; sh_shift = 1'b1;
    sel_c = 1'b1; sel_z = 1'b1; wr_c = 1'b1; wr_z = 1'b1;
    #1;
    chk("sel_sh_z", 32'(sh_z), 32'd1);
    step();
    wr_c = 1'b0; wr_z = 1'b0; sel_c = 1'b0; sel_z = 1'b0;
    #2;
    chk("sel_c_flag", 32'(c_flag), 32'd1);
    chk("sel_z_flag", 32'(z_flag), 32'd1);
    repeat (3) step();
    chk("hold_c_flag", 32'(c_flag), 32'd1);
    chk("hold_z_flag", 32'(z_flag), 32'd1);

    // Asynchronous reset mid-cycle
    mem_addr = 8'h10;
    #2 reset = 1'b1;
    #1;
    chk("arst_c_flag", 32'(c_flag), 32'd0);
    chk("arst_z_flag", 32'(z_flag), 32'd0);
    chk("arst_rd_10",  32'(mem_rdata), 32'h00);
    mem_we = 1'b1; mem_addr = 8'h20; mem_wdata = 8'h77;
    step();
    mem_addr = 8'h30; mem_wdata = 8'h33;
    #2 reset = 1'b0;
    #1;
    chk("rel_no_write", 32'(mem_rdata), 32'h00);
    step();
    mem_we = 1'b0;
    #1;
    chk("rel_write_30", 32'(mem_rdata), 32'h33);
    mem_addr = 8'h20;
    #1;
    chk("rst_we_ignored", 32'(mem_rdata), 32'h00);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step();
      alu_op    = 3'($urandom_range(0, 7));
      alu_a     = 8'($urandom);
      alu_b     = ($urandom_range(0, 7) == 0) ? alu_a : 8'($urandom);
      alu_use_c = 1'($urandom);
      sh_data   = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      sh_count  = 3'($urandom);
      sh_dir    = 1'($urandom);
      sh_shift  = 1'($urandom);
      mem_we    = 1'($urandom);
      mem_addr  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      mem_wdata = 8'($urandom);
      sel_c     = 1'($urandom);
      sel_z     = 1'($urandom);
      wr_c      = 1'($urandom);
      wr_z      = 1'($urandom);
    end
    step();
    mem_we = 1'b0; wr_c = 1'b0; wr_z = 1'b0;
    repeat (2) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
